// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types, constants and helpers for the arbiter-side
//                packet multiplexer (port count, source index width, FSM
//                state encoding, one-hot helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_PORT = 4;
    localparam int SRC_W  = 2;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Binary index of the set bit; only meaningful for one-hot input.
    function automatic logic [SRC_W-1:0] onehot2bin(input logic [N_PORT-1:0] g);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (g[i]) idx = SRC_W'(i);
        end
        return idx;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [N_PORT-1:0] g);
        return (g != '0) && ((g & (g - N_PORT'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_out_slice.sv
`default_nettype none
// ============================================================================
//  Module      : arb_out_slice
//  Description : One-deep valid/ready register slice. Holds its beat while
//                the consumer stalls and accepts a new beat in the same cycle
//                the current one drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_out_slice #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load;

    // Room exists when the slot is empty or its beat leaves this cycle.
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Valid flag: set on load, cleared when drained without a replacement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register: only written on an accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_pkt_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkt_mux
//  Description : Packet-granular 4:1 mux behind a round-robin arbiter. Locks
//                onto the granted source and forwards its stream through a
//                one-deep output slice until the last beat, then releases.
//                Optional stall watchdog: define ARB_PKT_MUX_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pkt_mux
    import arb_pkg::*;
#(
    parameter int         DW     = 32,
    parameter logic [7:0] TO_CYC = 8'd255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_PORT-1:0]    gnt,
    input  logic [N_PORT-1:0]    s_valid,
    input  logic [N_PORT*DW-1:0] s_data,
    input  logic [N_PORT-1:0]    s_last,
    output logic [N_PORT-1:0]    s_ready,
    output logic                 m_valid,
    output logic [DW-1:0]        m_data,
    output logic                 m_last,
    output logic [SRC_W-1:0]     m_src,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 err_gnt,
    output logic                 err_timeout
);

    localparam int SW = DW + 1 + SRC_W;

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] sel_q, sel_d;
    logic             err_gnt_d;

    logic [DW-1:0]    src_data [N_PORT];
    logic             sel_valid;
    logic             sel_last;
    logic [DW-1:0]    sel_data;
    logic             slot_ready;
    logic             xfer;
    logic [SW-1:0]    slot_in;
    logic [SW-1:0]    slot_out;

    // Unpack the flat payload bus into one word per source.
    for (genvar i = 0; i < N_PORT; i++) begin : g_src
        assign src_data[i] = s_data[i*DW +: DW];
    end

    // Only the locked source's signals are ever looked at.
    assign sel_valid = s_valid[sel_q];
    assign sel_last  = s_last[sel_q];
    assign sel_data  = src_data[sel_q];

    assign busy = (state_q == ARB_BUSY);
    assign xfer = busy && sel_valid && slot_ready;

    // Ready goes only to the locked source, and only while the slice has room.
    always_comb begin
        s_ready = '0;
        if (busy) s_ready[sel_q] = slot_ready;
    end

    assign slot_in = {sel_last, sel_q, sel_data};

    arb_out_slice #(
        .W (SW)
    ) u_slice (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (xfer),
        .in_ready  (slot_ready),
        .in_data   (slot_in),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (slot_out)
    );

    assign m_last = slot_out[SW-1];
    assign m_src  = slot_out[DW +: SRC_W];
    assign m_data = slot_out[DW-1:0];

`ifdef ARB_PKT_MUX_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_to_q, err_to_d;

    assign err_timeout = err_to_q;
`else
    // No watchdog: the lock is held for as long as the source stalls.
    assign err_timeout = 1'b0 & (|TO_CYC);
`endif

    // Lock FSM: grant capture, end-of-packet release, illegal-grant flagging.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_gnt_d = 1'b0;
`ifdef ARB_PKT_MUX_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_to_d  = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
`ifdef ARB_PKT_MUX_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (is_onehot(gnt)) begin
                    sel_d   = onehot2bin(gnt);
                    state_d = ARB_BUSY;
                end else if (gnt != '0) begin
                    err_gnt_d = 1'b1;
                end
            end
            ARB_BUSY: begin
                // The arbiter is masked by busy, so any grant here is a fault.
                if (gnt != '0) err_gnt_d = 1'b1;
                if (xfer && sel_last) state_d = ARB_IDLE;
`ifdef ARB_PKT_MUX_TIMEOUT_EN
                if (xfer) begin
                    cnt_d = '0;
                end else if (cnt_q + 8'd1 == TO_CYC) begin
                    // Force release; whatever sits in the slice still drains.
                    cnt_d    = '0;
                    state_d  = ARB_IDLE;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, selection and error-pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            err_gnt <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_gnt <= err_gnt_d;
        end
    end

`ifdef ARB_PKT_MUX_TIMEOUT_EN
    // Stall counter and timeout pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            err_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_pkt_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_pkt_mux
//  Description : Self-checking bench for arb_pkt_mux: directed packet
//                scenarios plus randomized packets against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_pkt_mux;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    src;
    } beat_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [3:0]      gnt;
    logic [3:0]      s_valid;
    logic [4*DW-1:0] s_data;
    logic [3:0]      s_last;
    logic [3:0]      s_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [1:0]      m_src;
    logic            m_ready;
    logic            busy;
    logic            err_gnt;
    logic            err_timeout;

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t exp_q [$];
    beat_t e;
    bit    mon_en  = 1'b0;
    bit    stalled = 1'b0;

    arb_pkt_mux #(
        .DW     (DW),
        .TO_CYC (8'd255)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .gnt         (gnt),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_src       (m_src),
        .m_ready     (m_ready),
        .busy        (busy),
        .err_gnt     (err_gnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every delivered beat must be the oldest accepted one.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            chk("s_ready_onehot0", 64'($onehot0(s_ready)), 64'(1));
`ifndef ARB_PKT_MUX_TIMEOUT_EN
            chk("err_timeout_zero", 64'(err_timeout), 64'(0));
`endif
            if (stalled) chk("stall_hold", 64'(m_valid), 64'(1));
            stalled = m_valid && !m_ready;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", 64'(m_data), 64'(e.data));
                    chk("m_last", 64'(m_last), 64'(e.last));
                    chk("m_src",  64'(m_src),  64'(e.src));
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // rmode: 0 = always ready/valid, 1 = random, 2 = ready pattern 1,0,0,1.
    // inj:   loop cycle on which a stray grant 1000 is driven (-1 = none).
    // bub:   previous packet ended on the prior edge; expect one empty cycle.
    task automatic run_packet(input int src, input int len, input logic [DW-1:0] base,
                              input int rmode, input int inj, input bit bub);
        logic [DW-1:0] pkt [$];
        logic [3:0]    pat;
        int            sent;
        int            cyc;
        bit            acc;
        pat  = 4'b1001;
        sent = 0;
        cyc  = 0;
        for (int i = 0; i < len; i++)
            pkt.push_back(rmode == 1 ? DW'($urandom()) : base + DW'(i));

        // Grant cycle: source offers its first beat, but nothing is ready yet.
        gnt     = 4'(1 << src);
        m_ready = (rmode == 1 && !bub) ? 1'($urandom_range(0, 1)) : 1'b1;
        s_valid = 4'($urandom()) | 4'(1 << src);
        s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_data[src*DW +: DW] = pkt[0];
        s_last  = 4'($urandom());
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_s_ready", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        gnt = '0;
        chk("grant_busy", 64'(busy), 64'(1));
        chk("grant_err_gnt", 64'(err_gnt), 64'(0));

        while (sent < len && cyc < 200) begin
            s_valid = 4'($urandom());
            s_valid[src] = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_data[src*DW +: DW] = pkt[sent];
            s_last  = 4'($urandom());
            s_last[src] = (sent == len - 1);
            case (rmode)
                1:       m_ready = 1'($urandom_range(0, 2) != 0);
                2:       m_ready = (cyc < 4) ? pat[3 - cyc] : 1'b1;
                default: m_ready = 1'b1;
            endcase
            gnt = (cyc == inj) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            if (bub && cyc == 0) chk("bubble_m_valid", 64'(m_valid), 64'(0));
            chk("s_ready_sel", 64'(s_ready[src]), 64'(!m_valid || m_ready));
            chk("s_ready_other", 64'(s_ready & ~4'(1 << src)), 64'(0));
            acc = s_valid[src] && s_ready[src];
            if (acc) begin
                exp_q.push_back('{data: pkt[sent], last: (sent == len - 1), src: 2'(src)});
                sent++;
            end
            @(posedge clk); #1;
            if (cyc == inj) begin
                chk("err_gnt_busy", 64'(err_gnt), 64'(1));
                chk("busy_after_stray_gnt", 64'(busy), 64'(1));
            end
            if (acc && sent == len) chk("busy_fall", 64'(busy), 64'(0));
            cyc++;
        end
        gnt     = '0;
        s_valid = '0;
        if (sent < len) chk("packet_budget", 64'(sent), 64'(len));
    endtask

    initial begin
        rstn    = 1'b0;
        gnt     = '0;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_m_src", 64'(m_src), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err_gnt", 64'(err_gnt), 64'(0));
        chk("rst_err_timeout", 64'(err_timeout), 64'(0));
        @(posedge clk); #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Three-beat packet from source 0 at full rate.
        run_packet(0, 3, 32'hA0, 0, -1, 1'b0);

        // Back-pressure on source 2.
        run_packet(2, 3, 32'h200, 2, -1, 1'b0);

        // Illegal multi-hot grant in IDLE.
        m_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        gnt = 4'b0110;
        @(negedge clk);
        chk("illegal_s_ready", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        gnt = '0;
        chk("illegal_err_gnt", 64'(err_gnt), 64'(1));
        chk("illegal_busy", 64'(busy), 64'(0));
        chk("illegal_s_ready_after", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        chk("illegal_err_gnt_clear", 64'(err_gnt), 64'(0));

        // Stray grant while locked to source 1.
        run_packet(1, 4, 32'h100, 0, 1, 1'b0);

        // Tightest turnaround: source 3 then source 1 right after.
        run_packet(3, 2, 32'h300, 0, -1, 1'b0);
        run_packet(1, 2, 32'h110, 0, -1, 1'b1);

        // One-beat packet.
        run_packet(2, 1, 32'h2F0, 0, -1, 1'b0);

        // Randomized packets.
        for (int p = 0; p < 30; p++)
            run_packet(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), '0, 1, -1, 1'b0);

        // Drain everything outstanding.
        m_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("drained", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of a packet drops it.
        mon_en  = 1'b0;
        gnt     = 4'b0001;
        @(posedge clk); #1;
        gnt     = '0;
        s_valid = 4'b0001;
        s_last  = '0;
        m_ready = 1'b0;
        @(posedge clk); #1;
        chk("midpkt_m_valid", 64'(m_valid), 64'(1));
        rstn = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_s_ready", 64'(s_ready), 64'(0));
        s_valid = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        run_packet(3, 2, 32'h3A0, 0, -1, 1'b0);
        m_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_pkt_mux.md
# arb_pkt_mux

Packet-granular 4:1 data multiplexer that sits directly downstream of the 4-port round-robin arbiter and consumes its registered one-hot `gnt`. On a valid grant it locks onto the granted source and forwards that source's valid/ready stream, beat by beat, through a one-deep output register until the beat flagged `last`. It then releases the lock. While locked it asserts `busy`; the arbiter's request inputs are masked with `busy`, so no new grant arrives mid-packet.

## Interface
- `DW`, 32, payload width per source.
- `TO_CYC`, 8'd255, stall-watchdog limit in cycles (used only with `ARB_PKT_MUX_TIMEOUT_EN`).

- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `gnt`  in  4  registered one-hot grant from the arbiter; bit i selects source i.
- `s_valid`  in  4  per-source beat valid.
- `s_data`  in  4*DW  per-source payload; source i occupies `[i*DW +: DW]`.
- `s_last`  in  4  per-source end-of-packet flag.
- `s_ready`  out  4  per-source ready; at most one bit is high at a time.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  DW  output payload.
- `m_last`  out  1  output end-of-packet flag.
- `m_src`  out  2  index of the source that produced the current output beat.
- `m_ready`  in  1  downstream ready.
- `busy`  out  1  high while a packet is locked.
- `err_gnt`  out  1  one-cycle pulse on an illegal or unexpected grant.
- `err_timeout`  out  1  one-cycle pulse on a watchdog release.

## Operation
- State machine: IDLE and BUSY. `sel[1:0]` holds the locked source.
- **IDLE**
  - `s_ready` = 0.
  - If `gnt` is one-hot: latch `sel` = binary index of `gnt`, then go to BUSY.
  - If `gnt` is non-zero but not one-hot: pulse `err_gnt` and stay in IDLE.
  - If `gnt` = 0: stay in IDLE.
- **BUSY**
  - `s_ready[sel]` = `!m_valid || m_ready`. All other `s_ready` bits are 0.
  - A transfer occurs when `s_valid[sel] && s_ready[sel]`. It loads `m_data`, `m_last`, `m_src`=`sel` and sets `m_valid`.
  - A transfer with `s_last[sel]` = 1 returns the FSM to IDLE.
  - Any non-zero `gnt` while in BUSY is ignored and pulses `err_gnt`.
- **Output register**
  - Holds its content while `m_valid && !m_ready`.
  - Clears `m_valid` when `m_ready` is high and no new transfer occurs.
  - Accepts a new beat in the same cycle that the current beat drains.
- `busy` = (state == BUSY), driven combinationally from the state register.
- Unselected sources' `s_data` and `s_last` never reach the output.

## Timing
- Reset values:
  - state = IDLE, `sel` = 0.
  - `s_ready`, `m_valid`, `m_data`, `m_last`, `m_src`, `busy`, `err_gnt`, `err_timeout` all 0.
- A grant sampled at edge E sets `busy` after E. The first source beat can be accepted in the cycle following E.
- Source-to-output latency is 1 cycle: a beat accepted at edge E is visible on `m_*` after E.
- Full throughput is 1 beat/cycle while `m_ready` stays high.
- Packet turnaround:
  - A last beat accepted at E puts the FSM in IDLE after E.
  - The next grant is sampled at E+1 at the earliest.
  - This gives at least 1 bubble cycle between packets.
- A one-beat packet (`s_last` on the first beat) is legal: BUSY lasts exactly 1 cycle when ready.
- `m_ready` low with `m_valid` high: `s_ready[sel]` drops combinationally and no beat is lost or duplicated.
- A source deasserting `s_valid` mid-packet keeps the lock. With the watchdog compiled out, the lock is held indefinitely.
- Reset mid-packet: all state is cleared asynchronously and the partial packet is dropped. There is no recovery beat.

## Configuration
- `ARB_PKT_MUX_TIMEOUT_EN` defined:
  - An 8-bit stall counter runs in BUSY. It clears on every transfer and on entry to BUSY.
  - When the counter reaches `TO_CYC`, the FSM forces IDLE and pulses `err_timeout` for 1 cycle.
  - The output register is not flushed.
- `ARB_PKT_MUX_TIMEOUT_EN` undefined: no counter is built, `err_timeout` is tied to 0, and `TO_CYC` is unused.

## Structure
- Shared package `arb_pkg` contains:
  - `N_PORT` = 4 and `SRC_W` = 2.
  - The state enum `{ARB_IDLE, ARB_BUSY}`.
  - Function `onehot2bin(4-bit) -> 2-bit`.
  - Function `is_onehot(4-bit)`.
- One sub-module, `arb_out_slice`: the one-deep valid/ready register with parameter `DW+3`. It carries payload, last and src.
- The top level contains the FSM, the selection mux and the optional watchdog.

## Test plan
- After reset, `gnt`=0001 and source 0 sends a 3-beat packet 0xA0, 0xA1, 0xA2 (last) with `m_ready`=1 -> `m_data` shows A0, A1, A2 on consecutive cycles, starting 2 cycles after the grant edge; `m_src`=0; `m_last` only on A2; `busy` falls after A2 is accepted.
- While source 2 is locked, toggle `m_ready` 1,0,0,1 -> `s_ready[2]` follows back-pressure; output shows each beat exactly once in order; `m_valid` holds across the stall.
- `gnt`=0110 in IDLE -> `err_gnt` pulses for 1 cycle, state stays IDLE, all `s_ready` remain 0.
- `gnt`=1000 while locked to source 1 -> `err_gnt` pulses, `sel` stays 1, the packet completes from source 1.
- Packet from source 3, then `gnt`=0010 on the cycle after the last beat -> exactly 1 bubble cycle between the packets; the first beat of the second packet has `m_src`=1.
- With `ARB_PKT_MUX_TIMEOUT_EN`, `TO_CYC`=4: locked source stalls `s_valid`=0 -> `err_timeout` pulses after 4 idle BUSY cycles, `busy` drops, and a new grant is accepted.
